bram_init_seq: RTL and testbench
================================

// Module: bram_init_seq
// PURPOSE
//  Sequencer sitting directly in front of the 36-bit block-RAM wrapper. It owns the read and write
//  address/data ports of that RAM.
//  FILL mode writes a seed-derived pattern to every word. VERIFY mode reads every word back,
//  compares it against the same pattern, counts mismatches and folds the readback into a signature.
//  Used to confirm in hardware that a bitstream memory reinit landed correctly.
// PARAMETERS
//  DATA_W     36    RAM word width
//  ADDR_W     10    RAM address width
//  DEPTH      1024  words swept per operation; DEPTH <= 2**ADDR_W
// PORTS
//  clk             in   1        clock, all state on posedge
//  reset           in   1        asynchronous, active-low reset
//  start           in   1        request an operation; sampled only in IDLE
//  mode            in   1        0 = FILL, 1 = VERIFY; sampled with start
//  seed            in   DATA_W   pattern seed; sampled with start
//  busy            out  1        operation in progress
//  done            out  1        1-cycle pulse at end of operation
//  err_cnt         out  ADDR_W+1 VERIFY mismatch count
//  err_valid       out  1        at least one mismatch seen in last VERIFY
//  first_err_addr  out  ADDR_W   address of first mismatch
//  signature       out  DATA_W   rotate-XOR fold of VERIFY readback
//  mem_raddr       out  ADDR_W   RAM read address
//  mem_waddr       out  ADDR_W   RAM write address
//  mem_din         out  DATA_W   RAM write data
//  mem_we          out  1        RAM write enable; the attached RAM must gate its write with it
//  mem_dout        in   DATA_W   RAM read data; 1-cycle registered read
// BEHAVIOUR
//  - Reset (reset=0): state=IDLE. All outputs are 0, including mem_we.
//    Asserting reset mid-operation aborts immediately, with no done pulse. Result registers clear.
//  - pattern(a) = seed_q ^ zero_extend(a). seed_q is seed latched when start is accepted.
//  - States: IDLE, FILL, RD, DRAIN, DONE.
//  - IDLE:
//    - start=1 latches seed_q and mode, and clears addr to 0.
//    - mode=0 goes to FILL.
//    - mode=1 goes to RD and clears err_cnt, err_valid, first_err_addr and signature.
//    - start outside IDLE is ignored.
//  - FILL:
//    - Each cycle drives mem_we=1, mem_waddr=addr and mem_din=pattern(addr), then addr++.
//    - After addr=DEPTH-1 goes to DONE. That is exactly DEPTH write cycles.
//  - RD:
//    - Each cycle drives mem_raddr=addr, then addr++. The issued address is delayed 1 cycle to
//      align with mem_dout.
//    - After addr=DEPTH-1 goes to DRAIN.
//  - Compare (RD after its first cycle, and DRAIN): check mem_dout against pattern(delayed addr).
//    - On mismatch, err_cnt++ (cannot exceed DEPTH, so no overflow).
//    - On the first mismatch, set err_valid=1 and first_err_addr=delayed addr.
//    - signature <= {signature[DATA_W-2:0], signature[DATA_W-1]} ^ mem_dout.
//  - DRAIN: exactly one cycle, for the final compare; then goes to DONE.
//  - DONE: done=1 for one cycle, then IDLE. busy=1 in FILL, RD and DRAIN only.
//  - Latencies from the start-accept cycle:
//    - FILL: done is high DEPTH+1 cycles later.
//    - VERIFY: done is high DEPTH+2 cycles later.
//  - Results hold until the next VERIFY start or reset. FILL does not touch them.
//  - mem_we=0 in every state except FILL. mem_raddr and mem_waddr hold 0 outside their active state.
//  - All outputs are registered, except mem_din and mem_waddr, which are decoded from registered state.
// TESTING
//  - FILL seed=0 then VERIFY seed=0 -> err_cnt=0, err_valid=0, done 1025 / 1026 cycles after accept.
//  - FILL seed=36'hA5A5A5A5A; backdoor-corrupt word 5; VERIFY same seed -> err_cnt=1,
//    first_err_addr=5.
//  - FILL seed=0, VERIFY seed=36'h1 -> err_cnt=1024, err_valid=1, first_err_addr=0.
//  - Pulse start with mode=1 while FILL is busy at addr 100 -> ignored; FILL completes, and only
//    one done pulse occurs.
//  - Assert reset during FILL at addr 300 -> next cycle mem_we=0, busy=0, no done;
//    words 0..299 are written and word 300+ is unchanged.
//  - After FILL seed=0, VERIFY -> signature equals a reference-model fold over
//    words 0..1023 = zero_extend(addr).

Source files
------------

// File: rtl/bram_init_seq.sv
`default_nettype none
// ============================================================================
// bram_init_seq : fills a block RAM with seed^addr, or reads it back and checks it
// Revision 1.0
// ============================================================================
module bram_init_seq #(
  parameter int DATA_W = 36,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] signature,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_seed;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W-1:0] r_cmp_addr;
  logic              r_cmp_valid;
  logic [ADDR_W:0]   r_err_cnt;
  logic              r_err_valid;
  logic [ADDR_W-1:0] r_first_err;
  logic [DATA_W-1:0] r_sig;

  logic [DATA_W-1:0] w_wr_pattern;
  logic [DATA_W-1:0] w_cmp_pattern;
  logic              w_mismatch;

  assign w_wr_pattern  = r_seed ^ {{(DATA_W-ADDR_W){1'b0}}, r_addr};
  assign w_cmp_pattern = r_seed ^ {{(DATA_W-ADDR_W){1'b0}}, r_cmp_addr};
  assign w_mismatch    = (mem_dout != w_cmp_pattern);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_seed      <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_raddr     <= '0;
      r_cmp_addr  <= '0;
      r_cmp_valid <= 1'b0;
      r_err_cnt   <= '0;
      r_err_valid <= 1'b0;
      r_first_err <= '0;
      r_sig       <= '0;
    end else begin
      r_done      <= 1'b0;
      // RAM read data lags the issued address by one cycle
      r_cmp_valid <= (r_state == S_RD);
      r_cmp_addr  <= r_raddr;

      if (r_cmp_valid) begin
        r_sig <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ mem_dout;
        if (w_mismatch) begin
          r_err_cnt <= r_err_cnt + 1'b1;
          if (!r_err_valid) begin
            r_err_valid <= 1'b1;
            r_first_err <= r_cmp_addr;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed  <= seed;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            if (!mode) begin
              r_state <= S_FILL;
              r_we    <= 1'b1;
            end else begin
              r_state     <= S_RD;
              r_raddr     <= '0;
              r_err_cnt   <= '0;
              r_err_valid <= 1'b0;
              r_first_err <= '0;
              r_sig       <= '0;
            end
          end
        end
        S_FILL: begin
          if (r_addr == c_last) begin
            r_state <= S_DONE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_RD: begin
          if (r_addr == c_last) begin
            r_state <= S_DRAIN;
            r_addr  <= '0;
            r_raddr <= '0;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_raddr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign err_cnt        = r_err_cnt;
  assign err_valid      = r_err_valid;
  assign first_err_addr = r_first_err;
  assign signature      = r_sig;
  assign mem_raddr      = r_raddr;
  assign mem_we         = r_we;
  assign mem_waddr      = (r_state == S_FILL) ? r_addr : '0;
  assign mem_din        = (r_state == S_FILL) ? w_wr_pattern : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_init_seq.sv
`default_nettype none
// tb_bram_init_seq : scoreboard bench with a 1-cycle registered RAM model behind the sequencer.
module tb_bram_init_seq;

  localparam int DATA_W = 36;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   err_cnt;
  logic              err_valid;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] signature;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  always #5 clk = ~clk;

  bram_init_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .err_cnt(err_cnt), .err_valid(err_valid),
    .first_err_addr(first_err_addr), .signature(signature),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // RAM model with a backdoor write port for corruption
  logic [DATA_W-1:0] ram [DEPTH];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    if (bd_we)  ram[bd_addr]   <= bd_data;
    mem_dout <= ram[mem_raddr];
  end

  typedef struct {
    int                lat;
    logic [ADDR_W:0]   err_cnt;
    logic              err_valid;
    logic [ADDR_W-1:0] fea;
    logic [DATA_W-1:0] sig;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [ADDR_W:0]   m_err_cnt;
  logic              m_err_valid;
  logic [ADDR_W-1:0] m_fea;
  logic [DATA_W-1:0] m_sig;
  int total = 0;
  int bad   = 0;

  task automatic predict(input logic m, input logic [DATA_W-1:0] s);
    exp_t e;
    logic [DATA_W-1:0] p;
    if (!m) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = s ^ DATA_W'(i);
      e.lat = DEPTH + 1;
    end else begin
      m_err_cnt = '0; m_err_valid = 1'b0; m_fea = '0; m_sig = '0;
      for (int i = 0; i < DEPTH; i++) begin
        p = s ^ DATA_W'(i);
        m_sig = {m_sig[DATA_W-2:0], m_sig[DATA_W-1]} ^ shadow[i];
        if (shadow[i] !== p) begin
          if (!m_err_valid) m_fea = ADDR_W'(i);
          m_err_valid = 1'b1;
          m_err_cnt   = m_err_cnt + 1'b1;
        end
      end
      e.lat = DEPTH + 2;
    end
    e.err_cnt = m_err_cnt; e.err_valid = m_err_valid; e.fea = m_fea; e.sig = m_sig;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic m, input logic [DATA_W-1:0] s, input int inject_at,
                        input string name);
    exp_t e;
    int   cnt;
    int   dones;
    logic injected;
    injected = 1'b0;
    predict(m, s);
    @(negedge clk); start = 1'b1; mode = m; seed = s;
    @(posedge clk);
    @(negedge clk); start = 1'b0; mode = 1'b0; seed = '0; cnt = 1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_accept: got %b want 1", name, busy); end
    while (!done && cnt < 3000) begin
      if (inject_at >= 0 && !injected && mem_waddr == ADDR_W'(inject_at)) begin
        start = 1'b1; mode = 1'b1; seed = 36'h3; injected = 1'b1;
      end else begin
        start = 1'b0; mode = 1'b0;
      end
      @(negedge clk); cnt++;
    end
    start = 1'b0; mode = 1'b0;
    e = sb.pop_front();
    dones = done ? 1 : 0;
    total++;
    if (cnt !== e.lat) begin bad++; $display("FAIL %s done_latency: got %0d want %0d", name, cnt, e.lat); end
    for (int k = 0; k < ((inject_at >= 0) ? 1100 : 3); k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones !== 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", name, dones); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after: got %b want 0", name, busy); end
    total++;
    if (err_cnt !== e.err_cnt) begin bad++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, e.err_cnt); end
    total++;
    if (err_valid !== e.err_valid) begin bad++; $display("FAIL %s err_valid: got %b want %b", name, err_valid, e.err_valid); end
    total++;
    if (first_err_addr !== e.fea) begin bad++; $display("FAIL %s first_err_addr: got %0d want %0d", name, first_err_addr, e.fea); end
    total++;
    if (signature !== e.sig) begin bad++; $display("FAIL %s signature: got %h want %h", name, signature, e.sig); end
    if (inject_at >= 0) begin
      total++;
      if (injected !== 1'b1) begin bad++; $display("FAIL %s inject_reached: got %b want 1", name, injected); end
    end
  endtask

  task automatic check_ram(input string name);
    int diffs;
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== shadow[i]) diffs++;
    total++;
    if (diffs !== 0) begin bad++; $display("FAIL %s ram_contents: got %0d bad words want 0", name, diffs); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mode = 1'b0; seed = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, mem_we, err_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, mem_we, err_valid});
    end
    total++;
    if ({err_cnt, first_err_addr, signature, mem_raddr, mem_waddr, mem_din} !== '0) begin
      bad++; $display("FAIL reset_values: got nonzero err_cnt=%0d sig=%h want all 0", err_cnt, signature);
    end
    reset = 1'b1;
    @(negedge clk);
    m_err_cnt = '0; m_err_valid = 1'b0; m_fea = '0; m_sig = '0;
  endtask

  task automatic test_fill_verify_zero();
    run_op(1'b0, 36'h0, -1, "fill_zero");
    check_ram("fill_zero");
    run_op(1'b1, 36'h0, -1, "verify_zero");
  endtask

  task automatic test_corrupt();
    run_op(1'b0, 36'hA5A5A5A5A, -1, "fill_a5");
    check_ram("fill_a5");
    @(negedge clk); bd_we = 1'b1; bd_addr = 10'd5; bd_data = shadow[5] ^ 36'h400;
    @(negedge clk); bd_we = 1'b0;
    shadow[5] = shadow[5] ^ 36'h400;
    run_op(1'b1, 36'hA5A5A5A5A, -1, "verify_corrupt");
  endtask

  task automatic test_seed_mismatch();
    run_op(1'b0, 36'h0, -1, "fill_zero2");
    run_op(1'b1, 36'h1, -1, "verify_seed1");
  endtask

  task automatic test_start_ignored();
    run_op(1'b0, 36'h123456789, 100, "fill_ignore_start");
    check_ram("fill_ignore_start");
  endtask

  task automatic test_reset_mid_fill();
    int cnt;
    int dones;
    run_op(1'b0, 36'h0, -1, "fill_before_abort");
    @(negedge clk); start = 1'b1; mode = 1'b0; seed = 36'hF0F0F0F0F;
    @(posedge clk);
    @(negedge clk); start = 1'b0; seed = '0; cnt = 0;
    while (mem_waddr != 10'd300 && cnt < 2000) begin @(negedge clk); cnt++; end
    total++;
    if (mem_waddr !== 10'd300) begin bad++; $display("FAIL abort_reach300: got %0d want 300", mem_waddr); end
    reset = 1'b0;
    #1;
    total++;
    if ({mem_we, busy} !== 2'b00) begin bad++; $display("FAIL abort_outputs: got we,busy=%b want 00", {mem_we, busy}); end
    dones = 0;
    repeat (3) begin @(negedge clk); if (done) dones++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (done) dones++; end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    for (int i = 0; i < 300; i++) shadow[i] = 36'hF0F0F0F0F ^ DATA_W'(i);
    m_err_cnt = '0; m_err_valid = 1'b0; m_fea = '0; m_sig = '0;
    total++;
    if ({err_cnt, err_valid, first_err_addr, signature} !== '0) begin
      bad++; $display("FAIL abort_results_clear: got err_cnt=%0d sig=%h want 0", err_cnt, signature);
    end
    check_ram("abort_partial");
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 36'hF0F0F0F0F, -1, "verify_partial");
    run_op(1'b1, 36'h0, -1, "verify_partial_seed0");
  endtask

  initial begin
    test_reset();
    test_fill_verify_zero();
    test_corrupt();
    test_seed_mismatch();
    test_start_ignored();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
